// File: rtl/pipe_stage_buf_pkg.sv
// Shared sizing helpers and occupancy encoding for the pipeline stage buffer.
package pipe_stage_buf_pkg;

    // Occupancy classes of the buffer; PARTIAL is unreachable when DEPTH=1.
    typedef enum logic [1:0] {
        OccEmpty   = 2'd0,
        OccPartial = 2'd1,
        OccFull    = 2'd2
    } occ_e;

    // Pointer width; a single-entry buffer still carries a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width, able to represent 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Producer/consumer handshake bundle for pipe_stage_buf.
interface pipe_stage_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
);
    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Environment side: drives the producer payload and the consumer ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Pointer, occupancy and handshake control for pipe_stage_buf.
// Ready/valid come from registered occupancy only, so there is no
// combinational path from out_ready to in_ready.
module pipe_stage_ctrl
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic                          out_ready,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic                          push,
    output logic                          pop,
    output logic [ptr_width(DEPTH)-1:0]   wr_ptr,
    output logic [ptr_width(DEPTH)-1:0]   rd_ptr,
    output logic [cnt_width(DEPTH)-1:0]   count
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    occ_e          occ;

    // Classify current occupancy from the registered count.
    always_comb begin
        if (count_q == '0) begin
            occ = OccEmpty;
        end else if (count_q == FULL_CNT) begin
            occ = OccFull;
        end else begin
            occ = OccPartial;
        end
    end

    // A full buffer refuses input even if it pops this cycle; flush kills both transfers.
    always_comb begin
        in_ready  = (occ != OccFull);
        out_valid = (occ != OccEmpty);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Next-state: flush wins, otherwise advance pointers and step the count by +/-1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case (occ)
                OccEmpty: begin
                    if (push) count_d = count_q + 1'b1;
                end
                OccFull: begin
                    if (pop) count_d = count_q - 1'b1;
                end
                default: begin
                    if (push && !pop) begin
                        count_d = count_q + 1'b1;
                    end else if (pop && !push) begin
                        count_d = count_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Control state register with asynchronous reset to empty.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Small FIFO pipeline stage buffer: registered ready/valid, 1-cycle latency,
// BUBBLE presented while empty, synchronous flush, async active-low reset.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned     WIDTH  = 32,
    parameter int unsigned     DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               flush,
    pipe_stage_buf_if.slave    bus
);
    localparam int unsigned PW    = ptr_width(DEPTH);
    localparam int unsigned CW    = cnt_width(DEPTH);
    // Storage rounded up to the pointer range so every pointer value indexes a real slot.
    localparam int unsigned SLOTS = 2 ** PW;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem_q [SLOTS];

    pipe_stage_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Payload storage; not reset because empty slots are masked by BUBBLE.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr] <= bus.in_data;
        end
    end

    // Present the oldest entry, or the NOP encoding when nothing is held.
    always_comb begin
        bus.out_data  = out_valid ? mem_q[rd_ptr] : BUBBLE;
        bus.out_valid = out_valid;
        bus.in_ready  = in_ready;
        bus.count     = count;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a DEPTH=2 instance (directed + random)
// and a DEPTH=3 instance with a non-zero BUBBLE (random, pointer wrap).
// Reference model is a plain queue per instance, updated on each rising edge
// from the acceptance rules; monitors compare DUT outputs on the falling edge.
module tb_pipe_stage_buf;

    localparam int unsigned W        = 32;
    localparam logic [W-1:0] BUBBLE_B = 32'hDEAD_BEEF;

    logic CLK = 1'b0;
    logic nRST;
    logic flush_a;
    logic flush_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];

    pipe_stage_buf_if #(.WIDTH(W), .DEPTH(2)) bus_a ();
    pipe_stage_buf_if #(.WIDTH(W), .DEPTH(3)) bus_b ();

    pipe_stage_buf #(
        .WIDTH  (W),
        .DEPTH  (2),
        .BUBBLE ('0)
    ) u_dut_a (
        .CLK   (CLK),
        .nRST  (nRST),
        .flush (flush_a),
        .bus   (bus_a)
    );

    pipe_stage_buf #(
        .WIDTH  (W),
        .DEPTH  (3),
        .BUBBLE (BUBBLE_B)
    ) u_dut_b (
        .CLK   (CLK),
        .nRST  (nRST),
        .flush (flush_b),
        .bus   (bus_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model A: a queue of capacity 2.
    always @(posedge CLK) begin : model_a
        int sz;
        bit pu, po;
        if (nRST !== 1'b1 || flush_a) begin
            q_a.delete();
        end else begin
            sz = q_a.size();
            pu = bus_a.in_valid && (sz != 2);
            po = bus_a.out_ready && (sz != 0);
            if (po) void'(q_a.pop_front());
            if (pu) q_a.push_back(bus_a.in_data);
        end
    end

    // Reference model B: a queue of capacity 3.
    always @(posedge CLK) begin : model_b
        int sz;
        bit pu, po;
        if (nRST !== 1'b1 || flush_b) begin
            q_b.delete();
        end else begin
            sz = q_b.size();
            pu = bus_b.in_valid && (sz != 3);
            po = bus_b.out_ready && (sz != 0);
            if (po) void'(q_b.pop_front());
            if (pu) q_b.push_back(bus_b.in_data);
        end
    end

    // Monitor A: every falling edge out of reset.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin : mon_a
            int sz;
            sz = q_a.size();
            check("a_count", W'(bus_a.count), W'(sz));
            check("a_in_ready", W'(bus_a.in_ready), W'(sz != 2));
            check("a_out_valid", W'(bus_a.out_valid), W'(sz != 0));
            if (sz != 0) check("a_out_data", bus_a.out_data, q_a[0]);
            else         check("a_bubble", bus_a.out_data, '0);
        end
    end

    // Monitor B: every falling edge out of reset.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin : mon_b
            int sz;
            sz = q_b.size();
            check("b_count", W'(bus_b.count), W'(sz));
            check("b_in_ready", W'(bus_b.in_ready), W'(sz != 3));
            check("b_out_valid", W'(bus_b.out_valid), W'(sz != 0));
            if (sz != 0) check("b_out_data", bus_b.out_data, q_b[0]);
            else         check("b_bubble", bus_b.out_data, BUBBLE_B);
        end
    end

    // Drive A for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic cyc_a(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bus_a.in_valid  = v;
        bus_a.in_data   = d;
        bus_a.out_ready = r;
        flush_a         = f;
        @(negedge CLK);
    endtask

    task automatic cyc_b(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bus_b.in_valid  = v;
        bus_b.in_data   = d;
        bus_b.out_ready = r;
        flush_b         = f;
        @(negedge CLK);
    endtask

    // Watchdog: the run is cycle-bounded, this only catches a stuck simulator.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state.
        check("rst_count", W'(bus_a.count), 0);
        check("rst_in_ready", W'(bus_a.in_ready), 1);
        check("rst_out_valid", W'(bus_a.out_valid), 0);
        check("rst_out_data", bus_a.out_data, '0);
        check("rst_b_out_data", bus_b.out_data, BUBBLE_B);
        nRST = 1'b1;

        // Fill to full without consuming.
        cyc_a(1, 32'hA, 0, 0);
        cyc_a(1, 32'hB, 0, 0);
        check("fill_count", W'(bus_a.count), 2);
        check("fill_in_ready", W'(bus_a.in_ready), 0);
        check("fill_out_data", bus_a.out_data, 32'hA);

        // Drain in order, then bubble.
        cyc_a(0, 0, 1, 0);
        check("drain_first", bus_a.out_data, 32'hB);
        cyc_a(0, 0, 1, 0);
        check("drain_valid", W'(bus_a.out_valid), 0);
        check("drain_bubble", bus_a.out_data, '0);

        // Streaming: one in, one out per cycle at occupancy 1.
        for (int i = 1; i <= 10; i++) begin
            cyc_a(1, W'(i), 1, 0);
            check("stream_data", bus_a.out_data, W'(i));
            check("stream_count", W'(bus_a.count), 1);
        end
        cyc_a(0, 0, 1, 0);

        // Full with simultaneous pop: the push must be refused.
        cyc_a(1, 32'h1, 0, 0);
        cyc_a(1, 32'h2, 0, 0);
        cyc_a(1, 32'h3, 1, 0);
        check("fullpop_count", W'(bus_a.count), 1);
        check("fullpop_data", bus_a.out_data, 32'h2);
        cyc_a(0, 0, 1, 0);

        // Flush beats a concurrent push and pop.
        cyc_a(1, 32'h11, 0, 0);
        cyc_a(1, 32'h22, 0, 0);
        cyc_a(1, 32'h33, 1, 1);
        check("flush_count", W'(bus_a.count), 0);
        check("flush_valid", W'(bus_a.out_valid), 0);
        cyc_a(0, 0, 1, 0);
        check("flush_no_33", W'(bus_a.out_valid), 0);

        // Asynchronous reset between edges with two entries held.
        cyc_a(1, 32'h44, 0, 0);
        cyc_a(0, 32'h55, 0, 0);
        cyc_a(1, 32'h55, 0, 0);
        bus_a.in_valid = 1'b0;
        #2 nRST = 1'b0;
        q_a.delete(); q_b.delete();
        #1;
        check("arst_count", W'(bus_a.count), 0);
        check("arst_valid", W'(bus_a.out_valid), 0);
        check("arst_in_ready", W'(bus_a.in_ready), 1);
        check("arst_data", bus_a.out_data, '0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc_a(1, 32'h66, 0, 0);
        check("post_rst_data", bus_a.out_data, 32'h66);
        check("post_rst_count", W'(bus_a.count), 1);
        cyc_a(0, 0, 1, 0);

        // Random traffic on A.
        for (int i = 0; i < 300; i++) begin
            cyc_a(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0));
        end
        cyc_a(0, 0, 0, 0);

        // DEPTH=3: interleaved pushes/pops forcing pointer wrap.
        for (int i = 0; i < 7; i++) begin
            cyc_b(1, W'(32'h100 + i), 0, 0);
            cyc_b(1, W'(32'h200 + i), 1, 0);
        end
        for (int i = 0; i < 4; i++) cyc_b(0, 0, 1, 0);
        check("b_drained", W'(bus_b.count), 0);

        // Random traffic on B.
        for (int i = 0; i < 400; i++) begin
            cyc_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));
        end
        cyc_b(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits (1..512).
REQ-002 Parameter DEPTH, 2, buffer entries (1..4); DEPTH=1 is a plain enabled pipeline register.
REQ-003 Parameter BUBBLE, '0, WIDTH-bit value driven on out_data when empty (NOP encoding).
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  producer has a payload.
REQ-008 in_data  input  WIDTH  producer payload.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 out_valid  output  1  oldest entry presented.
REQ-011 out_data  output  WIDTH  oldest entry, or BUBBLE when empty.
REQ-012 out_ready  input  1  consumer takes the entry this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-015 Entries SHALL leave in FIFO order; an entry pushed at edge N SHALL be visible on out_data/out_valid after edge N (latency 1, no combinational in->out path).
REQ-016 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-017 When full, a simultaneous pop SHALL NOT permit a same-cycle push; in_ready stays 0 that cycle.
REQ-018 Simultaneous push and pop when not full and not empty SHALL leave count unchanged and advance both pointers.
REQ-019 Push and pop in the same cycle from empty SHALL be impossible (out_valid=0); the push alone SHALL occur.
REQ-020 out_valid SHALL equal (count != 0); out_data SHALL equal BUBBLE whenever out_valid=0.
REQ-021 Without push or pop, all state SHALL hold (stall).
REQ-022 flush SHALL take priority over push and pop: next state count=0, pointers 0, out_data=BUBBLE; the incoming payload that cycle SHALL be discarded.
REQ-023 Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions only by +1 (push only), -1 (pop only) or to EMPTY (flush/reset). For DEPTH=1 PARTIAL does not exist.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH)-bit (1 bit minimum) and wrap from DEPTH-1 to 0, including non-power-of-two DEPTH=3.
REQ-025 Storage contents of popped or flushed slots are don't-care and SHALL never reach out_data.

Reset
REQ-026 nRST low SHALL immediately and asynchronously force count=0, pointers=0, out_valid=0, out_data=BUBBLE, in_ready=1.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; no payload accepted before reset SHALL appear after release.
REQ-028 Storage array need not be reset.

Structure
REQ-029 No package additions are required; instantiations carrying CPU stage payloads SHALL size WIDTH from cpu_types_pkg struct widths ($bits of the stage struct).
REQ-030 Pointer/count logic MAY be split into sub-module pipe_stage_ctrl (pointers, count, ready/valid); storage and output mux stay in pipe_stage_buf.

Verification
REQ-031 WIDTH=32, DEPTH=2: push 0xA, 0xB on consecutive cycles with out_ready=0 -> count=2, in_ready=0, out_data=0xA.
REQ-032 Continue: out_ready=1 two cycles, in_valid=0 -> out_data 0xA then 0xB, then out_valid=0, out_data=0.
REQ-033 Streaming in_valid=out_ready=1 with data 1..10 -> out_data 1..10 in order, one per cycle after first, count constant 1.
REQ-034 Full with 0x11,0x22; flush=1 with in_valid=1, in_data=0x33 -> next cycle count=0, out_valid=0, 0x33 never appears.
REQ-035 DEPTH=3: 7 pushes/pops interleaved -> pointer wrap correct, order preserved, no entry lost or duplicated.
REQ-036 nRST pulsed low between edges with count=2 -> outputs reset immediately; after release first out_data equals first post-reset push.
